// File: rtl/wb_master_standard_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths and FSM state type for the Wishbone block master.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 16;
  localparam int LEN_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    BUS    = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_master_standard_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_wb
// Description : Wishbone classic bus bundle. Data names are slave-relative:
//               dat_i carries write data into the slave, dat_o read data out.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_wb (
  input wire logic clk,
  input wire logic rst
);

  logic                      cyc;
  logic                      stb;
  logic                      we;
  logic [wb_pkg::ADR_W-1:0]  adr;
  logic [wb_pkg::DAT_W-1:0]  dat_i;
  logic [wb_pkg::DAT_W-1:0]  dat_o;
  logic                      ack;

  modport master (
    input  clk, rst, dat_o, ack,
    output cyc, stb, we, adr, dat_i
  );

  modport slave (
    input  clk, rst, cyc, stb, we, adr, dat_i,
    output dat_o, ack
  );

endinterface
`default_nettype wire

// File: rtl/wb_master_standard_timeout.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_timeout
// Description : Counts strobe cycles without acknowledge and flags expiry in
//               the TIMEOUT-th such cycle. An ack in that same cycle masks
//               expiry so the beat completes normally. TIMEOUT=0 disables it.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic start,
  input  wire logic ack,
  input  wire logic enable,
  output logic      expired
);

  localparam int            CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] C_MAX  = '1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_cur;

  // count of earlier stalled strobe cycles, forced to zero on a fresh strobe
  assign cnt_cur = start ? '0 : cnt_q;

  assign expired = (TIMEOUT != 0) && enable && !ack && (cnt_cur == C_LAST);

  // accumulate stalled strobe cycles; any idle cycle or ack clears the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!enable || ack) begin
      cnt_q <= '0;
    end else if (cnt_cur != C_MAX) begin
      cnt_q <= cnt_cur + 1'b1;
    end else begin
      cnt_q <= cnt_cur;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_master_standard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wb_master_standard
// Description : Wishbone classic block master. Accepts a read or write block
//               command, runs one standard cycle per beat with a one-cycle
//               idle gap between beats, streams read data out and pulses
//               done (with done_err on timeout) at block end.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_master_standard
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  if_wb.master             wb,
  input  wire logic             cmd_valid,
  output logic                  cmd_ready,
  input  wire logic             cmd_we,
  input  wire logic [ADR_W-1:0] cmd_adr,
  input  wire logic [LEN_W-1:0] cmd_len,
  input  wire logic             wdat_valid,
  output logic                  wdat_ready,
  input  wire logic [DAT_W-1:0] wdat,
  output logic                  rsp_valid,
  output logic [DAT_W-1:0]      rsp_dat,
  output logic                  done,
  output logic                  done_err
);

  state_t             state_q;
  logic               cyc_q;
  logic               stb_q;
  logic               stb_prev_q;
  logic               we_q;
  logic [ADR_W-1:0]   adr_q;
  logic [DAT_W-1:0]   dat_q;
  logic [LEN_W-1:0]   len_q;
  logic               rsp_valid_q;
  logic [DAT_W-1:0]   rsp_dat_q;
  logic               done_q;
  logic               done_err_q;
  logic               stb_rise;
  logic               expired;

  // handshake readies are state decodes, held low while reset is asserted
  assign cmd_ready  = !wb.rst && (state_q == IDLE);
  assign wdat_ready = !wb.rst && (state_q == FETCH);

  assign wb.cyc     = cyc_q;
  assign wb.stb     = stb_q;
  assign wb.we      = we_q;
  assign wb.adr     = adr_q;
  assign wb.dat_i   = dat_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign done       = done_q;
  assign done_err   = done_err_q;

  assign stb_rise   = stb_q && !stb_prev_q;

  // remember last strobe level to detect the start of each beat
  always_ff @(posedge wb.clk or posedge wb.rst) begin
    if (wb.rst) begin
      stb_prev_q <= 1'b0;
    end else begin
      stb_prev_q <= stb_q;
    end
  end

  wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (wb.clk),
    .rst     (wb.rst),
    .start   (stb_rise),
    .ack     (wb.ack),
    .enable  (stb_q),
    .expired (expired)
  );

  // block sequencer: command latch, write-data fetch, bus beats, completion
  always_ff @(posedge wb.clk or posedge wb.rst) begin
    if (wb.rst) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      len_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            we_q  <= cmd_we;
            adr_q <= cmd_adr;
            len_q <= cmd_len;
            if (cmd_we) begin
              state_q <= FETCH;
            end else begin
              state_q <= BUS;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (wdat_valid) begin
            dat_q   <= wdat;
            state_q <= BUS;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
          end
        end
        BUS: begin
          if (!stb_q) begin
            // inter-beat gap of a read block is over; ack here is ignored
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
          end else if (wb.ack) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            if (!we_q) begin
              rsp_dat_q   <= wb.dat_o;
              rsp_valid_q <= 1'b1;
            end
            if (len_q == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              len_q <= len_q - 1'b1;
              adr_q <= adr_q + 1'b1;
              if (we_q) begin
                state_q <= FETCH;
              end
            end
          end else if (expired) begin
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            state_q    <= FINISH;
            done_q     <= 1'b1;
            done_err_q <= 1'b1;
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_standard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wb_master_standard
// Description : Scoreboard bench: stimulus pushes expected beats, read data
//               and completion status; a negedge monitor pops and compares.
//               Slave is a memory with configurable wait, no-ack and
//               spurious-ack behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_master_standard;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_wb wb (.clk(clk), .rst(rst));

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [15:0] cmd_adr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wdat_valid = 1'b0;
  logic        wdat_ready;
  logic [15:0] wdat = '0;
  logic        rsp_valid;
  logic [15:0] rsp_dat;
  logic        done;
  logic        done_err;

  wb_master_standard #(.TIMEOUT(TO)) dut (
    .wb         (wb),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_len    (cmd_len),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat       (wdat),
    .rsp_valid  (rsp_valid),
    .rsp_dat    (rsp_dat),
    .done       (done),
    .done_err   (done_err)
  );

  // ---------------- slave memory model ----------------
  logic [15:0] mem     [0:65535];
  logic [15:0] ref_mem [0:65535];
  int          slv_wait = 0;
  bit          slv_noack = 1'b0;
  bit          slv_spur = 1'b0;
  int          scnt = 0;
  bit          init_pending = 1'b1;
  bit          ld_en = 1'b0;
  logic [15:0] ld_adr = '0;
  logic [15:0] ld_dat = '0;

  function automatic logic [15:0] f_init(int a);
    return 16'(a * 40503) ^ 16'hA5C3;
  endfunction

  always_comb begin
    wb.ack = 1'b0;
    if (wb.cyc && wb.stb) wb.ack = !slv_noack && (scnt == slv_wait);
    else                  wb.ack = slv_spur;
  end
  assign wb.dat_o = mem[wb.adr];

  always @(posedge clk) begin
    if (wb.cyc && wb.stb && !wb.ack) scnt <= scnt + 1;
    else                             scnt <= 0;
    if (init_pending) begin
      for (int i = 0; i < 65536; i++) mem[i] <= f_init(i);
    end else begin
      if (ld_en) mem[ld_adr] <= ld_dat;
      if (wb.cyc && wb.stb && wb.ack && wb.we) mem[wb.adr] <= wb.dat_i;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] adr;
    bit          we;
    logic [15:0] dat;
    int          cycles;
    bit          tmo;
    bit          rd_more;
  } beat_t;

  beat_t       exp_beats[$];
  logic [15:0] exp_rsp[$];
  bit          exp_done[$];
  logic [15:0] wq[$];
  logic [15:0] touched[$];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  int    run = 0;
  int    acks_seen = 0;
  bit    g1 = 0, g1_rd = 0, g1_more = 0, g2 = 0;
  beat_t mb;

  always @(negedge clk) begin
    if (rst) begin
      run = 0; g1 = 0; g2 = 0;
    end else begin
      if (g2) begin
        chk("regap_stb", 32'(wb.stb), 1);
        g2 = 0;
      end
      if (g1) begin
        chk("gap_cyc_stb", 32'({wb.cyc, wb.stb}), 0);
        if (g1_rd) chk("rsp_latency", 32'(rsp_valid), 1);
        g2 = g1_more;
        g1 = 0;
      end
      if (rsp_valid) begin
        chk("rsp_pending", 32'(exp_rsp.size() != 0), 1);
        if (exp_rsp.size() != 0) chk("rsp_dat", 32'(rsp_dat), 32'(exp_rsp.pop_front()));
      end
      if (done) begin
        chk("done_cmd_ready", 32'(cmd_ready), 0);
        chk("done_pending", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) chk("done_err", 32'(done_err), 32'(exp_done.pop_front()));
      end
      if (wb.stb) begin
        run++;
        if (wb.ack) begin
          acks_seen++;
          chk("beat_pending", 32'(exp_beats.size() != 0), 1);
          if (exp_beats.size() != 0) begin
            mb = exp_beats.pop_front();
            chk("beat_not_timeout", 32'(mb.tmo), 0);
            chk("beat_adr", 32'(wb.adr), 32'(mb.adr));
            chk("beat_we", 32'(wb.we), 32'(mb.we));
            if (mb.we) chk("beat_wdat", 32'(wb.dat_i), 32'(mb.dat));
            chk("beat_stb_cycles", 32'(run), 32'(mb.cycles));
            g1 = 1; g1_rd = !mb.we; g1_more = mb.rd_more;
          end
          run = 0;
        end
      end else if (run != 0) begin
        chk("abort_pending", 32'(exp_beats.size() != 0), 1);
        if (exp_beats.size() != 0) begin
          mb = exp_beats.pop_front();
          chk("abort_expected", 32'(mb.tmo), 1);
          chk("abort_stb_cycles", 32'(run), 32'(mb.cycles));
        end
        run = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic setup_expect(input bit we, input logic [15:0] adr, input int len,
                              input bit noack, input bit seq);
    logic [15:0] a;
    logic [15:0] d;
    wq.delete();
    for (int i = 0; i <= len; i++) begin
      a = adr + 16'(i);
      d = seq ? 16'(i + 1) : 16'($urandom);
      if (noack) begin
        if (i == 0) begin
          exp_beats.push_back('{a, we, d, TO, 1'b1, 1'b0});
          if (we) wq.push_back(d);
        end
      end else begin
        exp_beats.push_back('{a, we, d, slv_wait + 1, 1'b0, (!we && i < len)});
        if (we) begin
          wq.push_back(d);
          ref_mem[a] = d;
          touched.push_back(a);
        end else begin
          exp_rsp.push_back(ref_mem[a]);
        end
      end
    end
    exp_done.push_back(noack);
  endtask

  task automatic issue_cmd(input bit we, input logic [15:0] adr, input int len);
    int n = 0;
    cmd_we = we; cmd_adr = adr; cmd_len = 8'(len); cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_accept", 32'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
  endtask

  task automatic feed_writes(input int starve_beat, input int starve_n);
    int n;
    for (int i = 0; i < wq.size(); i++) begin
      if (i == starve_beat) begin
        n = 0;
        while (!wdat_ready && n < 200) begin @(negedge clk); n++; end
        repeat (starve_n) begin
          chk("starve_cyc", 32'(wb.cyc), 0);
          @(negedge clk);
        end
      end
      wdat = wq[i]; wdat_valid = 1'b1;
      n = 0;
      while (!wdat_ready && n < 200) begin @(negedge clk); n++; end
      chk("wdat_accept", 32'(wdat_ready), 1);
      @(posedge clk); #1 wdat_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_done.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", 32'(exp_done.size()), 0);
    chk("beats_left", 32'(exp_beats.size()), 0);
    chk("rsp_left", 32'(exp_rsp.size()), 0);
    @(negedge clk);
  endtask

  task automatic run_cmd(input bit we, input logic [15:0] adr, input int len, input int wt,
                         input bit noack, input int starve_beat, input int starve_n, input bit seq);
    slv_wait = wt; slv_noack = noack;
    setup_expect(we, adr, len, noack, seq);
    issue_cmd(we, adr, len);
    if (we) feed_writes(starve_beat, starve_n);
    wait_done();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] a;
    int          base;
    int          n;
    int          len;
    bit          we;
    for (int i = 0; i < 65536; i++) ref_mem[i] = f_init(i);
    repeat (3) @(negedge clk);
    chk("rst_cyc", 32'(wb.cyc), 0);
    chk("rst_stb", 32'(wb.stb), 0);
    chk("rst_we", 32'(wb.we), 0);
    chk("rst_adr", 32'(wb.adr), 0);
    chk("rst_dat_i", 32'(wb.dat_i), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_done", 32'({done, done_err}), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    init_pending = 1'b0;
    rst = 1'b0;
    #1 chk("cmd_ready_after_rst", 32'(cmd_ready), 1);
    @(negedge clk);

    // single read of a preloaded word, zero-wait slave
    ld_adr = 16'h0010; ld_dat = 16'hBEEF; ld_en = 1'b1;
    ref_mem[16'h0010] = 16'hBEEF;
    @(negedge clk); ld_en = 1'b0;
    run_cmd(1'b0, 16'h0010, 0, 0, 1'b0, -1, 0, 1'b0);

    // four-beat write with data 1..4, two-wait slave
    run_cmd(1'b1, 16'h0100, 3, 2, 1'b0, -1, 0, 1'b1);
    for (int i = 0; i < 4; i++) chk("ram_seq", 32'(mem[16'h0100 + 16'(i)]), 32'(i + 1));

    // write-data starvation before the second beat
    run_cmd(1'b1, 16'h0200, 3, 1, 1'b0, 1, 5, 1'b0);

    // address wrap
    run_cmd(1'b0, 16'hFFFF, 1, 1, 1'b0, -1, 0, 1'b0);

    // timeout abort, then ack landing in the final allowed cycle
    run_cmd(1'b0, 16'h1234, 3, 0, 1'b1, -1, 0, 1'b0);
    run_cmd(1'b1, 16'h2000, 1, 0, 1'b1, -1, 0, 1'b0);
    run_cmd(1'b0, 16'h1234, 1, TO - 1, 1'b0, -1, 0, 1'b0);

    // reset during beat 2 of a 4-beat read
    slv_wait = 3; slv_noack = 1'b0;
    setup_expect(1'b0, 16'h3000, 3, 1'b0, 1'b0);
    base = acks_seen;
    issue_cmd(1'b0, 16'h3000, 3);
    n = 0;
    while (!(acks_seen == base + 1 && wb.stb) && n < 200) begin @(negedge clk); n++; end
    chk("mid_beat2_reached", 32'(wb.stb), 1);
    #3 rst = 1'b1;
    #1 chk("async_rst_cyc_stb", 32'({wb.cyc, wb.stb}), 0);
    exp_beats.delete(); exp_rsp.delete(); exp_done.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 0);
    end
    rst = 1'b0;
    #1 chk("cmd_ready_after_mid_rst", 32'(cmd_ready), 1);
    @(negedge clk);
    run_cmd(1'b0, 16'h3000, 1, 0, 1'b0, -1, 0, 1'b0);

    // randomized blocks
    for (int k = 0; k < 24; k++) begin
      we  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 5);
      a   = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFD + $urandom_range(0, 2)) : 16'($urandom);
      slv_spur = 1'($urandom_range(0, 1));
      run_cmd(we, a, len, $urandom_range(0, 3), 1'b0,
              (len > 0) ? $urandom_range(1, len) : -1, $urandom_range(0, 3), 1'b0);
    end
    slv_spur = 1'b0;
    @(negedge clk);
    foreach (touched[i]) chk("ram_final", 32'(mem[touched[i]]), 32'(ref_mem[touched[i]]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
